mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter CALC_CYCLES, default 1: cycles spent in CALC before the product is captured; legal range 1..4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester n presents an operand pair.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  arbiter accepts requester n this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16 each  signed two's-complement operands.
REQ-007 SHALL have port rsp_valid  output  1  product available.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes the product.
REQ-009 SHALL have port rsp_data  output  32  signed product of the accepted operands.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns rsp_data.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, RESP.
REQ-013 IDLE: req_ready SHALL be high for exactly the granted requester, and only if its valid is high; both readys SHALL be low in CALC and RESP.
REQ-014 Grant SHALL be round-robin: with both valids high, grant the requester not granted last; after reset, requester 0 has priority.
REQ-015 With one valid high, that requester SHALL be granted regardless of priority; granting it SHALL update the last-granted pointer.
REQ-016 Handshake (valid & ready) SHALL register the operands and the id and move IDLE->CALC in the same edge.
REQ-017 Operands SHALL remain stable in internal registers from accept until the product is captured; requester inputs after the accept SHALL NOT affect the product.
REQ-018 CALC SHALL last exactly CALC_CYCLES cycles, timed by a down-counter; on expiry the product SHALL be registered into rsp_data and the state SHALL move to RESP.
REQ-019 The accept-to-rsp_valid latency SHALL be CALC_CYCLES+1 cycles.
REQ-020 RESP: rsp_valid SHALL be high, and rsp_data/rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-021 RESP with rsp_ready high SHALL move to IDLE, and a new grant SHALL occur no earlier than the following cycle.
REQ-022 There SHALL be at most one operation in flight; throughput is one product per CALC_CYCLES+2 cycles minimum.
REQ-023 Arithmetic SHALL be full signed 16x16->32 with no saturation; -32768*-32768 SHALL yield 32'h40000000.
REQ-024 A valid deasserted without a handshake SHALL be legal and SHALL cause no state change.

Reset
REQ-025 With rst_n low at a clock edge, the block SHALL enter the following reset state: state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; busy=0; both req_ready=0 during reset; priority pointer selects requester 0; CALC counter cleared.
REQ-026 Reset in CALC or RESP SHALL discard the in-flight operation, and no rsp_valid SHALL follow from it.
REQ-027 On the first cycle after rst_n goes high, arbitration SHALL resume normally.

Structure
REQ-028 The FSM state encoding and the CALC_CYCLES legal-range constants SHALL live in a shared package, mul_pkg.
REQ-029 The block SHALL instantiate exactly one existing combinational Booth/Wallace multiplier module as its sole sub-module, fed from the operand registers.
REQ-030 Arbitration, the counter and the FSM SHALL be local logic; rsp_data SHALL be driven directly from a register.

Verification
REQ-031 Single request: req0 a=3, b=-5, rsp_ready=1 -> rsp_valid after 2 cycles (default parameter), rsp_data=-15, rsp_id=0.
REQ-032 Corner operands: a=-32768, b=-32768 -> 32'h40000000; a=32767, b=-32768 -> 32'hC0008000.
REQ-033 Contention: both valids held high for four operations (req0 7*6, req1 -2*9) -> ids 0,1,0,1 with data 42, -18 alternating.
REQ-034 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, both readys low; completion on the first rsp_ready high.
REQ-035 Reset mid-CALC (CALC_CYCLES=3, rst_n low for one cycle at the 2nd CALC cycle) -> busy=0 and rsp_valid never asserted; next request after reset is served by requester 0 first.
REQ-036 Operand change: drive a new req0_a the cycle after accept -> product reflects the originally accepted operands.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the two-requester multiply arbiter: FSM encoding,
// operand/product widths and the legal range of the CALC duration.
package mul_pkg;

   localparam int CALC_CYCLES_MIN = 1;
   localparam int CALC_CYCLES_MAX = 4;
   localparam int CNT_W           = $clog2(CALC_CYCLES_MAX + 1);
   localparam int OP_W            = 16;
   localparam int PROD_W          = 2 * OP_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Out-of-range CALC durations are pinned to the nearest legal value.
   function automatic int clamp_calc(input int cycles);
      if (cycles < CALC_CYCLES_MIN) return CALC_CYCLES_MIN;
      if (cycles > CALC_CYCLES_MAX) return CALC_CYCLES_MAX;
      return cycles;
   endfunction

endpackage

// File: rtl/mul_arbiter_booth.sv
// Combinational signed 16x16->32 multiplier: radix-4 Booth partial products
// reduced by a carry-save (Wallace-style) chain and one final adder.
module mul_arbiter_booth
   import mul_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [PROD_W-1:0] p_o
);

   localparam int NPP = OP_W / 2;

   logic [PROD_W-1:0] a_ext;
   logic [PROD_W-1:0] a_neg;
   logic [OP_W:0]     b_pad;
   logic [PROD_W-1:0] pp [NPP];
   logic [PROD_W-1:0] csa_s;
   logic [PROD_W-1:0] csa_c;
   logic [PROD_W-1:0] csa_t;

   assign a_ext = {{(PROD_W - OP_W){a_i[OP_W-1]}}, a_i};
   assign a_neg = ~a_ext + PROD_W'(1);
   assign b_pad = {b_i, 1'b0};

   generate
      for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
         logic [2:0]        trip;
         logic [PROD_W-1:0] sel;

         assign trip = b_pad[2*gi+2 -: 3];

         // Booth digit in {-2,-1,0,+1,+2} picks a multiple of a.
         always_comb begin
            case (trip)
               3'b001, 3'b010: sel = a_ext;
               3'b011:         sel = a_ext << 1;
               3'b100:         sel = a_neg << 1;
               3'b101, 3'b110: sel = a_neg;
               default:        sel = '0;
            endcase
         end

         assign pp[gi] = sel << (2 * gi);
      end
   endgenerate

   always_comb begin
      csa_s = pp[0];
      csa_c = '0;
      csa_t = '0;
      for (int i = 1; i < NPP; i++) begin
         csa_t = csa_s ^ csa_c ^ pp[i];
         csa_c = ((csa_s & csa_c) | (csa_s & pp[i]) | (csa_c & pp[i])) << 1;
         csa_s = csa_t;
      end
   end

   assign p_o = csa_s + csa_c;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter in front of a single multiplier: one operation in flight,
// IDLE -> CALC (CALC_CYCLES) -> RESP, response held until the consumer takes it.
module mul_arbiter
   import mul_pkg::*;
#(
   parameter int CALC_CYCLES = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req0_a,
   input  logic [OP_W-1:0]   req0_b,
   input  logic [OP_W-1:0]   req1_a,
   input  logic [OP_W-1:0]   req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [PROD_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              busy
);

   localparam int CALC_LOAD = clamp_calc(CALC_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [OP_W-1:0]   b_q, b_d;
   logic              id_q, id_d;
   logic [PROD_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_id_q, rsp_id_d;

   logic              grant_vld;
   logic              grant_id;
   logic              accept;
   logic [PROD_W-1:0] product;

   mul_arbiter_booth u_booth (
      .a_i (a_q),
      .b_i (b_q),
      .p_o (product)
   );

   // With both requesting, the one not served last wins; a lone requester always wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = ~last_q;
      end else if (req0_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b0;
      end else if (req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b1;
      end
   end

   assign accept     = rst_n && (state_q == ST_IDLE) && grant_vld;
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept && grant_id;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_CALC;
               cnt_d   = CNT_W'(CALC_LOAD);
               last_d  = grant_id;
               id_d    = grant_id;
               a_d     = grant_id ? req1_a : req0_a;
               b_d     = grant_id ? req1_b : req0_b;
            end
         end
         ST_CALC: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d    = ST_RESP;
               cnt_d      = '0;
               rsp_data_d = product;
               rsp_id_d   = id_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // last_q resets to 1 so requester 0 is preferred on the first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a transaction-level model checks the default instance
// every cycle; directed literals pin results; a CALC_CYCLES=3 instance covers reset mid-CALC.
module tb_mul_arbiter;

   localparam int C_MAIN = 1;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req0_valid, req1_valid, rsp_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
   logic [31:0] rsp_data;

   logic        d3_rst_n, d3_req0_valid, d3_req1_valid, d3_rsp_ready;
   logic [15:0] d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
   logic        d3_req0_ready, d3_req1_ready, d3_rsp_valid, d3_rsp_id, d3_busy;
   logic [31:0] d3_rsp_data;

   mul_arbiter #(.CALC_CYCLES(C_MAIN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
   );

   mul_arbiter #(.CALC_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(d3_rst_n),
      .req0_valid(d3_req0_valid), .req1_valid(d3_req1_valid),
      .req0_ready(d3_req0_ready), .req1_ready(d3_req1_ready),
      .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req1_a(d3_req1_a), .req1_b(d3_req1_b),
      .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
      .rsp_data(d3_rsp_data), .rsp_id(d3_rsp_id), .busy(d3_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mulx(input logic [15:0] a, input logic [15:0] b);
      int x;
      int y;
      x = int'($signed(a));
      y = int'($signed(b));
      return 32'(x * y);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Transaction model: an accepted op becomes visible C_MAIN cycles later and
   // stays until the consumer takes it; grants follow the round-robin rule.
   bit          m_known = 1'b0;
   bit          m_busy  = 1'b0;
   int          m_age   = 0;
   int          m_last  = 1;
   logic        m_id    = 1'b0;
   logic [31:0] m_data  = '0;
   int          m_g;
   bit          m_v;

   always @(negedge clk) begin
      m_v = m_known && m_busy && (m_age >= C_MAIN);
      m_g = -1;
      if (rst_n && m_known && !m_busy) begin
         if (req0_valid && req1_valid) m_g = 1 - m_last;
         else if (req0_valid)          m_g = 0;
         else if (req1_valid)          m_g = 1;
      end
      chk("model_req0_ready", 32'(req0_ready), 32'(m_g == 0));
      chk("model_req1_ready", 32'(req1_ready), 32'(m_g == 1));
      if (m_known) begin
         chk("model_busy", 32'(busy), 32'(m_busy));
         chk("model_rsp_valid", 32'(rsp_valid), 32'(m_v));
         if (m_v) begin
            chk("model_rsp_data", rsp_data, m_data);
            chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
         end
      end
      if (!rst_n) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_last  = 1;
      end else if (m_known) begin
         if (m_busy) begin
            if (m_v && rsp_ready) m_busy = 1'b0;
            else                  m_age++;
         end else if (m_g >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = (m_g == 1);
            m_data = (m_g == 1) ? mulx(req1_a, req1_b) : mulx(req0_a, req0_b);
            m_last = m_g;
         end
      end
   end

   // Runs one op on the default instance with rsp_ready high.
   task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input bit scramble, output int lat,
                         output logic [31:0] data, output logic rid);
      int w;
      if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
      else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
      w = 0;
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && w < 10) begin
         tick;
         @(negedge clk);
         w++;
      end
      if (w >= 10) chk("grant_timeout", 32'(w), 32'd0);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (scramble) begin
         if (id) req1_a = ~a;
         else    req0_a = ~a;
      end
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 12) begin
         tick;
         lat++;
         @(negedge clk);
      end
      data = rsp_data;
      rid  = rsp_id;
      tick;
   endtask

   int          lat, got, cyc, w;
   logic [31:0] data;
   logic        rid;
   bit          seen;
   logic [31:0] c_data [4];
   logic        c_id   [4];

   initial begin
      rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      d3_rst_n = 1'b0; d3_req0_valid = 1'b0; d3_req1_valid = 1'b0; d3_rsp_ready = 1'b1;
      d3_req0_a = '0; d3_req0_b = '0; d3_req1_a = '0; d3_req1_b = '0;
      repeat (3) tick;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);

      // Single request, issued in the first cycle out of reset.
      tick;
      rst_n = 1'b1;
      run_op(1'b0, 16'd3, 16'hFFFB, 1'b0, lat, data, rid);
      $display("op single id=%0d data=%h lat=%0d", rid, data, lat);
      chk("single_lat", 32'(lat), 32'd2);
      chk("single_data", data, 32'hFFFF_FFF1);
      chk("single_id", 32'(rid), 32'd0);

      run_op(1'b0, 16'h7FFF, 16'h8000, 1'b0, lat, data, rid);
      $display("op corner_a id=%0d data=%h", rid, data);
      chk("corner_max_min", data, 32'hC000_8000);
      run_op(1'b1, 16'h8000, 16'h8000, 1'b0, lat, data, rid);
      $display("op corner_b id=%0d data=%h", rid, data);
      chk("corner_min_min", data, 32'h4000_0000);
      chk("corner_min_min_id", 32'(rid), 32'd1);

      // Contention: both held high for four completions.
      req0_a = 16'd7; req0_b = 16'd6; req1_a = 16'hFFFE; req1_b = 16'd9;
      req0_valid = 1'b1; req1_valid = 1'b1;
      got = 0; cyc = 0;
      while (got < 4 && cyc < 60) begin
         @(negedge clk);
         if (rsp_valid) begin
            c_id[got] = rsp_id; c_data[got] = rsp_data;
            $display("op contention id=%0d data=%h", rsp_id, rsp_data);
            got++;
         end
         tick;
         cyc++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("contention_count", 32'(got), 32'd4);
      for (int i = 0; i < got; i++) begin
         chk("contention_id", 32'(c_id[i]), 32'(i % 2));
         chk("contention_data", c_data[i], (i % 2 == 1) ? 32'hFFFF_FFEE : 32'd42);
      end

      // Backpressure with requester 1 waiting throughout.
      rsp_ready = 1'b0;
      req0_a = 16'd100; req0_b = 16'hFFFD; req0_valid = 1'b1;
      @(negedge clk);
      chk("bp_grant", 32'(req0_ready), 32'd1);
      tick;
      req0_valid = 1'b0;
      req1_a = 16'd5; req1_b = 16'd5; req1_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!rsp_valid && w < 10) begin tick; w++; @(negedge clk); end
      chk("bp_reach_resp", 32'(rsp_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_data", rsp_data, 32'hFFFF_FED4);
         chk("bp_hold_id", 32'(rsp_id), 32'd0);
         chk("bp_hold_ready1", 32'(req1_ready), 32'd0);
         tick;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_complete_valid", 32'(rsp_valid), 32'd1);
      $display("op backpressure id=%0d data=%h", rsp_id, rsp_data);
      tick;
      @(negedge clk);
      chk("bp_after_valid", 32'(rsp_valid), 32'd0);
      tick;
      req1_valid = 1'b0;
      repeat (4) tick;

      run_op(1'b0, 16'd11, 16'd13, 1'b1, lat, data, rid);
      $display("op operand_change id=%0d data=%h", rid, data);
      chk("opchange_data", data, 32'd143);

      // CALC_CYCLES=3 instance: reset during the second CALC cycle.
      tick;
      d3_rst_n = 1'b1; d3_req0_a = 16'd5; d3_req0_b = 16'd5; d3_req0_valid = 1'b1;
      @(negedge clk);
      chk("d3_first_grant", 32'(d3_req0_ready), 32'd1);
      tick;
      d3_req0_valid = 1'b0;
      @(negedge clk);
      chk("d3_busy_calc", 32'(d3_busy), 32'd1);
      tick;
      d3_rst_n = 1'b0;
      tick;
      d3_rst_n = 1'b1;
      @(negedge clk);
      chk("d3_busy_after_rst", 32'(d3_busy), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (d3_rsp_valid) seen = 1'b1;
         tick;
      end
      chk("d3_no_stale_rsp", 32'(seen), 32'd0);
      d3_req0_a = 16'd2; d3_req0_b = 16'hFFF9; d3_req1_a = 16'd4; d3_req1_b = 16'd4;
      d3_req0_valid = 1'b1; d3_req1_valid = 1'b1;
      @(negedge clk);
      chk("d3_prio_req0", 32'(d3_req0_ready), 32'd1);
      chk("d3_prio_req1", 32'(d3_req1_ready), 32'd0);
      tick;
      d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!d3_rsp_valid && lat < 12) begin tick; lat++; @(negedge clk); end
      $display("op d3 id=%0d data=%h lat=%0d", d3_rsp_id, d3_rsp_data, lat);
      chk("d3_lat", 32'(lat), 32'd4);
      chk("d3_data", d3_rsp_data, 32'hFFFF_FFF2);
      chk("d3_id", 32'(d3_rsp_id), 32'd0);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
